// File: rtl/control_unit.sv
// rtl/control_unit.sv - Mini-SRC control sequencer (fetch, decode, execute T3-T7)
//
// Purpose: Moore sequencer that walks RST -> T0..T7 -> T0/HALT and drives the
// datapath control strobes for each step of the current instruction.
// Ports:
//   clock   in   system clock, rising edge
//   clear   in   synchronous active-high reset, returns to RST from any state
//   stop    in   halt request, honoured only at an instruction boundary
//   ir      in   instruction register, opcode = ir[31:27]
//   con_ff  in   branch condition from the CON flip-flop
//   bus_src out  one-hot bus driver select
//   reg_ld  out  register load enables
//   gr_sel  out  {Gra,Grb,Grc}
//   IncPC, Read, Write  out  PC increment and memory strobes
//   alu_op  out  ALU operation (0 when unused)
//   run     out  low only in RST and HALT
//   state   out  current state code (debug)
module control_unit #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        stop,
  input  logic [31:0] ir,
  input  logic        con_ff,
  output logic [9:0]  bus_src,
  output logic [11:0] reg_ld,
  output logic [2:0]  gr_sel,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic [3:0]  alu_op,
  output logic        run,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_RST = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
    S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALT = 4'd15
  } state_e;

  typedef struct packed {
    logic [9:0]  bus;
    logic [11:0] ld;
    logic [2:0]  gr;
    logic        inc;
    logic        rd;
    logic        wr;
    logic [3:0]  alu;
  } ctl_t;

  localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST  = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110, OP_ADDI = 5'b01100, OP_MUL = 5'b01111;
  localparam logic [4:0] OP_BR   = 5'b10011, OP_JR   = 5'b10100, OP_IN  = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111, OP_MFHI = 5'b11000, OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [9:0] B_PC = 10'h001, B_MDR = 10'h002, B_ZLO = 10'h004, B_ZHI = 10'h008;
  localparam logic [9:0] B_HI = 10'h010, B_LO = 10'h020, B_IN = 10'h040, B_C = 10'h080;
  localparam logic [9:0] B_R  = 10'h100, B_BA = 10'h200;

  localparam logic [11:0] L_PC = 12'h001, L_MAR = 12'h002, L_MDR = 12'h004, L_IR = 12'h008;
  localparam logic [11:0] L_Y = 12'h010, L_ZLO = 12'h020, L_ZHI = 12'h040, L_HI = 12'h080;
  localparam logic [11:0] L_LO = 12'h100, L_OUT = 12'h200, L_CON = 12'h400, L_RIN = 12'h800;

  localparam logic [2:0] GRA = 3'b100, GRB = 3'b010, GRC = 3'b001;
  localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT);

  state_e     state_q, state_d;
  logic [2:0] wait_q, wait_d;
  ctl_t       ctl_q;
  logic       run_q;
  logic       fin;
  logic [4:0] opcode;
  logic       unused_ir;

  assign opcode    = ir[31:27];
  assign unused_ir = ^ir[26:0];

  // Control word for a state; evaluated on entry so the outputs are registered.
  function automatic ctl_t decode(input state_e st, input logic [4:0] op, input logic con);
    ctl_t c;
    c = '0;
    case (st)
      S_T0: begin c.bus = B_PC; c.ld = L_PC | L_MAR; c.inc = 1'b1; end
      S_T1: begin c.rd = 1'b1; c.ld = L_MDR; end
      S_T2: begin c.bus = B_MDR; c.ld = L_IR; end
      S_T3: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_ADDI:
                              begin c.gr = GRB; c.bus = B_R;   c.ld = L_Y;   end
          OP_LDI, OP_LD, OP_ST: begin c.gr = GRB; c.bus = B_BA;  c.ld = L_Y;   end
          OP_MFHI:            begin c.gr = GRA; c.bus = B_HI;  c.ld = L_RIN; end
          OP_MFLO:            begin c.gr = GRA; c.bus = B_LO;  c.ld = L_RIN; end
          OP_IN:              begin c.gr = GRA; c.bus = B_IN;  c.ld = L_RIN; end
          OP_OUT:             begin c.gr = GRA; c.bus = B_R;   c.ld = L_OUT; end
          OP_JR:              begin c.gr = GRA; c.bus = B_R;   c.ld = L_PC;  end
          OP_BR:              begin c.gr = GRA; c.bus = B_R;   c.ld = L_CON; end
          default: ;
        endcase
      end
      S_T4: begin
        case (op)
          OP_ADD: begin c.gr = GRC; c.bus = B_R; c.ld = L_ZLO; c.alu = 4'd0; end
          OP_SUB: begin c.gr = GRC; c.bus = B_R; c.ld = L_ZLO; c.alu = 4'd1; end
          OP_AND: begin c.gr = GRC; c.bus = B_R; c.ld = L_ZLO; c.alu = 4'd2; end
          OP_OR:  begin c.gr = GRC; c.bus = B_R; c.ld = L_ZLO; c.alu = 4'd3; end
          OP_MUL: begin c.gr = GRC; c.bus = B_R; c.ld = L_ZLO | L_ZHI; c.alu = 4'd4; end
          OP_ADDI, OP_LDI, OP_LD, OP_ST: begin c.bus = B_C; c.ld = L_ZLO; end
          OP_BR:  begin c.bus = B_PC; c.ld = L_Y; end
          default: ;
        endcase
      end
      S_T5: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LDI:
                       begin c.bus = B_ZLO; c.gr = GRA; c.ld = L_RIN; end
          OP_LD, OP_ST: begin c.bus = B_ZLO; c.ld = L_MAR; end
          OP_MUL:      begin c.bus = B_ZLO; c.ld = L_LO; end
          OP_BR:       begin c.bus = B_C;   c.ld = L_ZLO; end
          default: ;
        endcase
      end
      S_T6: begin
        case (op)
          OP_LD:  begin c.rd = 1'b1; c.ld = L_MDR; end
          OP_ST:  begin c.gr = GRA; c.bus = B_R; c.ld = L_MDR; end
          OP_MUL: begin c.bus = B_ZHI; c.ld = L_HI; end
          // Branch taken decision uses con_ff as seen on entry to T6.
          OP_BR:  if (con) begin c.bus = B_ZLO; c.ld = L_PC; end
          default: ;
        endcase
      end
      S_T7: begin
        case (op)
          OP_LD: begin c.bus = B_MDR; c.gr = GRA; c.ld = L_RIN; end
          OP_ST: c.wr = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
    return c;
  endfunction

  // Memory steps hold their state while the wait counter drains; fin marks
  // the last cycle of an instruction, where stop is allowed to take effect.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    fin     = 1'b0;
    case (state_q)
      S_RST: state_d = S_T0;
      S_T0:  begin state_d = S_T1; wait_d = WAIT_LOAD; end
      S_T1:  if (wait_q != 3'd0) wait_d = wait_q - 3'd1; else state_d = S_T2;
      S_T2:  state_d = S_T3;
      S_T3: begin
        case (opcode)
          OP_HALT: state_d = S_HALT;
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LDI,
          OP_LD, OP_ST, OP_MUL, OP_BR: state_d = S_T4;
          default: fin = 1'b1;
        endcase
      end
      S_T4: state_d = S_T5;
      S_T5: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LDI: fin = 1'b1;
          OP_LD:   begin state_d = S_T6; wait_d = WAIT_LOAD; end
          default: state_d = S_T6;
        endcase
      end
      S_T6: begin
        case (opcode)
          OP_LD:   if (wait_q != 3'd0) wait_d = wait_q - 3'd1; else state_d = S_T7;
          OP_ST:   begin state_d = S_T7; wait_d = WAIT_LOAD; end
          default: fin = 1'b1;
        endcase
      end
      S_T7: begin
        if (opcode == OP_ST && wait_q != 3'd0) wait_d = wait_q - 3'd1;
        else fin = 1'b1;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
    if (fin) state_d = stop ? S_HALT : S_T0;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_RST;
      wait_q  <= 3'd0;
      ctl_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ctl_q   <= decode(state_d, opcode, con_ff);
      run_q   <= (state_d != S_RST) && (state_d != S_HALT);
    end
  end

  assign bus_src = ctl_q.bus;
  assign reg_ld  = ctl_q.ld;
  assign gr_sel  = ctl_q.gr;
  assign IncPC   = ctl_q.inc;
  assign Read    = ctl_q.rd;
  assign Write   = ctl_q.wr;
  assign alu_op  = ctl_q.alu;
  assign run     = run_q;
  assign state   = state_q;

endmodule
